dm_io_bus: RTL

//  Memory-mapped I/O front end between the single-cycle core's ALU/store path and the data memory.

---
 rtl/dm_io_bus.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/dm_io_bus.sv
// dm_io_bus: memory-mapped I/O front end between the core's load/store path and DataMemory.
// Addresses with alures[ADDR_IO_BIT]=0 pass through to DataMemory. Addresses with the bit set
// hit a small register bank: LEDs, synchronised switches, sticky switch-edge flags, and a
// compare/overflow timer that drives a registered irq. Reads are combinational and have no
// side effects. All register state updates on the rising clock edge.
//
// Bus handshake: there is no valid/ready pair. memWr is a single-cycle store strobe that is
// committed at the clock edge where it is high. memRd only qualifies dm_rd; dataRd is valid
// combinationally whenever alures is stable.
module dm_io_bus #(
  parameter int ADDR_IO_BIT = 12,
  parameter int SW_W        = 64,
  parameter int LED_W       = 8,
  parameter int TIMER_W     = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [63:0]        alures,
  input  logic [63:0]        datawr,
  input  logic               memWr,
  input  logic               memRd,
  input  logic [SW_W-1:0]    switchs,
  input  logic [63:0]        dm_rdata,
  output logic [11:0]        dm_addr,
  output logic               dm_wr,
  output logic               dm_rd,
  output logic [63:0]        dataRd,
  output logic [LED_W-1:0]   leds,
  output logic               irq
);

  // Register indices: offset = alures[11:3]; the byte lane bits [2:0] are ignored.
  localparam logic [8:0] IDX_LEDS   = 9'd0;
  localparam logic [8:0] IDX_SWITCH = 9'd1;
  localparam logic [8:0] IDX_SWEDGE = 9'd2;
  localparam logic [8:0] IDX_TIMER  = 9'd3;
  localparam logic [8:0] IDX_TCMP   = 9'd4;
  localparam logic [8:0] IDX_STATUS = 9'd5;
  localparam logic [8:0] IDX_CTRL   = 9'd6;

  logic             io_sel;
  logic [8:0]       reg_idx;
  logic             wr_io;
  logic             wr_leds, wr_swedge, wr_timer, wr_tcmp, wr_status, wr_ctrl;

  logic [LED_W-1:0]   leds_q;
  logic [SW_W-1:0]    sync_q [SYNC_STAGES];
  logic [SW_W-1:0]    sw_prev_q;
  logic [SW_W-1:0]    swedge_q;
  logic [SW_W-1:0]    sw_rise;
  logic [TIMER_W-1:0] timer_q;
  logic [TIMER_W-1:0] tcmp_q;
  logic [1:0]         status_q;
  logic [1:0]         ctrl_q;
  logic               irq_q;

  logic               tmr_match;
  logic               tmr_wrap;
  logic [63:0]        io_rdata;

  // Address bits outside the decoded fields and the upper store-data bits are not needed.
  logic unused_bits;
  assign unused_bits = &{1'b0, alures, datawr};

  assign io_sel  = alures[ADDR_IO_BIT];
  assign reg_idx = alures[11:3];
  assign wr_io   = memWr & io_sel;

  assign wr_leds   = wr_io && (reg_idx == IDX_LEDS);
  assign wr_swedge = wr_io && (reg_idx == IDX_SWEDGE);
  assign wr_timer  = wr_io && (reg_idx == IDX_TIMER);
  assign wr_tcmp   = wr_io && (reg_idx == IDX_TCMP);
  assign wr_status = wr_io && (reg_idx == IDX_STATUS);
  assign wr_ctrl   = wr_io && (reg_idx == IDX_CTRL);

  assign dm_addr = alures[11:0];
  assign dm_wr   = memWr & ~io_sel;
  assign dm_rd   = memRd & ~io_sel;
  assign leds    = leds_q;
  assign irq     = irq_q;

  // Rising edge seen on the last synchroniser stage relative to the previous cycle.
  assign sw_rise = sync_q[SYNC_STAGES-1] & ~sw_prev_q;

  // Timer events are evaluated on the pre-increment count and the current (old) TCMP.
  assign tmr_match = ctrl_q[0] && (timer_q == tcmp_q);
  assign tmr_wrap  = ctrl_q[0] && !wr_timer && (timer_q == {TIMER_W{1'b1}});

  // LED register: plain R/W, truncated store data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leds_q <= '0;
    end else if (wr_leds) begin
      leds_q <= datawr[LED_W-1:0];
    end
  end

  // Switch synchroniser chain plus the previous-value register used for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      sw_prev_q <= '0;
    end else begin
      sync_q[0] <= switchs;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      sw_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Sticky edge flags: a new rising edge wins over a W1C of the same bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      swedge_q <= '0;
    end else begin
      swedge_q <= (swedge_q & ~(wr_swedge ? datawr[SW_W-1:0] : '0)) | sw_rise;
    end
  end

  // Timer counter: a CPU write beats the increment; wraps naturally at the register width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else if (wr_timer) begin
      timer_q <= datawr[TIMER_W-1:0];
    end else if (ctrl_q[0]) begin
      timer_q <= timer_q + TIMER_W'(1);
    end
  end

  // Compare value and control register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcmp_q <= '1;
      ctrl_q <= '0;
    end else begin
      if (wr_tcmp) tcmp_q <= datawr[TIMER_W-1:0];
      if (wr_ctrl) ctrl_q <= datawr[1:0];
    end
  end

  // Status flags: hardware set wins over a W1C in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= '0;
    end else begin
      status_q <= (status_q & ~(wr_status ? datawr[1:0] : 2'b00)) | {tmr_wrap, tmr_match};
    end
  end

  // Interrupt request, registered from the current flags and enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= ctrl_q[1] & (status_q[0] | status_q[1]);
    end
  end

  // Combinational read mux: registers zero-extend to 64 bits; unmapped offsets read 0.
  always_comb begin
    io_rdata = '0;
    case (reg_idx)
      IDX_LEDS:   io_rdata[LED_W-1:0]   = leds_q;
      IDX_SWITCH: io_rdata[SW_W-1:0]    = sync_q[SYNC_STAGES-1];
      IDX_SWEDGE: io_rdata[SW_W-1:0]    = swedge_q;
      IDX_TIMER:  io_rdata[TIMER_W-1:0] = timer_q;
      IDX_TCMP:   io_rdata[TIMER_W-1:0] = tcmp_q;
      IDX_STATUS: io_rdata[1:0]         = status_q;
      IDX_CTRL:   io_rdata[1:0]         = ctrl_q;
      default:    io_rdata = '0;
    endcase
    dataRd = io_sel ? io_rdata : dm_rdata;
  end

endmodule
